// File: rtl/fma_sum_pipe.sv
// Mantissa sum/difference stage of the FMA datapath: magnitude add/subtract with
// carry, swap sign, zero flag and leading-zero count, in a 1- or 2-stage pipeline.
module fma_sum_pipe #(
  parameter int VEC_SIZE = 33,
  parameter int PIPE     = 2,
  parameter int LZC_W    = $clog2(VEC_SIZE + 3)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [VEC_SIZE:0]   pm,
  input  logic [VEC_SIZE:0]   am,
  input  logic                diff_sign,
  input  logic                z_zero,
  input  logic                no_product,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [VEC_SIZE+1:0] sm,
  output logic                swap,
  output logic                sum_zero,
  output logic [LZC_W-1:0]    lzc
);

  localparam int W = VEC_SIZE + 2;

  // Handshake: a beat transfers on a rising clk edge when valid && ready are both
  // high on that interface; valid never waits on ready, and a held output beat
  // keeps its data stable until it transfers.

  logic [W-1:0] pm_x;
  logic [W-1:0] am_x;
  logic [W-1:0] c_sm;
  logic         c_swap;

  assign pm_x = {1'b0, pm};
  assign am_x = {1'b0, am};

  always_comb begin
    c_sm   = '0;
    c_swap = 1'b0;
    if (z_zero && no_product) begin
      c_sm = '0;
    end else if (z_zero) begin
      c_sm = pm_x;
    end else if (no_product) begin
      c_sm   = am_x;
      c_swap = diff_sign;
    end else if (diff_sign) begin
      // Ties resolve toward the product so a zero difference keeps swap low.
      if (pm >= am) begin
        c_sm = pm_x - am_x;
      end else begin
        c_sm   = am_x - pm_x;
        c_swap = 1'b1;
      end
    end else begin
      c_sm = pm_x + am_x;
    end
  end

  // Highest set bit wins because the scan runs upward; all-zero yields W.
  function automatic logic [LZC_W-1:0] count_lz(input logic [W-1:0] v);
    count_lz = LZC_W'(W);
    for (int i = 0; i < W; i++) begin
      if (v[i]) count_lz = LZC_W'(W - 1 - i);
    end
  endfunction

  if (PIPE == 1) begin : g_pipe1
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        out_valid <= 1'b0;
        sm        <= '0;
        swap      <= 1'b0;
        sum_zero  <= 1'b0;
        lzc       <= '0;
      end else if (in_valid && in_ready) begin
        out_valid <= 1'b1;
        sm        <= c_sm;
        swap      <= c_swap;
        sum_zero  <= (c_sm == '0);
        lzc       <= count_lz(c_sm);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end else if (PIPE == 2) begin : g_pipe2
    logic         s1_valid;
    logic [W-1:0] s1_sm;
    logic         s1_swap;
    logic         s1_zero;
    logic         s1_adv;

    assign s1_adv   = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s1_adv;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1_valid <= 1'b0;
        s1_sm    <= '0;
        s1_swap  <= 1'b0;
        s1_zero  <= 1'b0;
      end else if (in_valid && in_ready) begin
        s1_valid <= 1'b1;
        s1_sm    <= c_sm;
        s1_swap  <= c_swap;
        s1_zero  <= (c_sm == '0);
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        out_valid <= 1'b0;
        sm        <= '0;
        swap      <= 1'b0;
        sum_zero  <= 1'b0;
        lzc       <= '0;
      end else if (s1_adv) begin
        out_valid <= 1'b1;
        sm        <= s1_sm;
        swap      <= s1_swap;
        sum_zero  <= s1_zero;
        lzc       <= count_lz(s1_sm);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end else begin : g_bad_pipe
    $error("fma_sum_pipe: PIPE must be 1 or 2");
  end

endmodule

// File: tb/tb_fma_sum_pipe.sv
// Bench for fma_sum_pipe: directed cases, backpressure, random streaming against
// an arithmetic reference model, and asynchronous reset, for PIPE=1 and PIPE=2.
module tb_fma_sum_pipe;
  localparam int VS = 15;
  localparam int W  = VS + 2;
  localparam int LW = 5;
  localparam int RW = W + 2 + LW;

  logic          clk = 1'b0;
  logic          reset;
  logic [VS:0]   pm, am;
  logic          diff_sign, z_zero, no_product;
  // Index 0 is the PIPE=1 instance, index 1 the PIPE=2 instance.
  logic          in_valid_d  [2];
  logic          in_ready_d  [2];
  logic          out_valid_d [2];
  logic          out_ready_d [2];
  logic [W-1:0]  sm_d        [2];
  logic          swap_d      [2];
  logic          sum_zero_d  [2];
  logic [LW-1:0] lzc_d       [2];

  int tests = 0;
  int fails = 0;
  logic [RW-1:0] exp_q[$];

  // ---- clock ----
  always #5 clk = ~clk;

  fma_sum_pipe #(.VEC_SIZE(VS), .PIPE(1)) dut_p1 (
    .clk(clk), .reset(reset), .in_valid(in_valid_d[0]), .in_ready(in_ready_d[0]),
    .pm(pm), .am(am), .diff_sign(diff_sign), .z_zero(z_zero), .no_product(no_product),
    .out_valid(out_valid_d[0]), .out_ready(out_ready_d[0]), .sm(sm_d[0]),
    .swap(swap_d[0]), .sum_zero(sum_zero_d[0]), .lzc(lzc_d[0]));

  fma_sum_pipe #(.VEC_SIZE(VS), .PIPE(2)) dut_p2 (
    .clk(clk), .reset(reset), .in_valid(in_valid_d[1]), .in_ready(in_ready_d[1]),
    .pm(pm), .am(am), .diff_sign(diff_sign), .z_zero(z_zero), .no_product(no_product),
    .out_valid(out_valid_d[1]), .out_ready(out_ready_d[1]), .sm(sm_d[1]),
    .swap(swap_d[1]), .sum_zero(sum_zero_d[1]), .lzc(lzc_d[1]));

  function automatic logic [RW-1:0] pack(logic [W-1:0] s, logic sw, logic z, logic [LW-1:0] l);
    return {s, sw, z, l};
  endfunction

  function automatic logic [RW-1:0] obs(int sel);
    return {sm_d[sel], swap_d[sel], sum_zero_d[sel], lzc_d[sel]};
  endfunction

  // Reference: plain signed integer arithmetic and a bit-length count.
  function automatic logic [RW-1:0] ref_model(logic [VS:0] p, logic [VS:0] a,
                                              logic ds, logic zz, logic np);
    int s;
    int lz;
    logic sw;
    sw = 1'b0;
    if (zz && np)  s = 0;
    else if (zz)   s = int'(p);
    else if (np) begin s = int'(a); sw = ds; end
    else if (ds) begin
      s = int'(p) - int'(a);
      if (s < 0) begin s = -s; sw = 1'b1; end
    end else       s = int'(p) + int'(a);
    lz = W;
    for (int t = s; t != 0; t = t >> 1) lz--;
    return pack(s[W-1:0], sw, s == 0, lz[LW-1:0]);
  endfunction

  // ---- scoreboard compare ----
  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // ---- driver tasks (called at posedge+1) ----
  task automatic set_in(logic [VS:0] p, logic [VS:0] a, logic ds, logic zz, logic np);
    pm = p; am = a; diff_sign = ds; z_zero = zz; no_product = np;
  endtask

  task automatic directed(string tag, int sel, logic [VS:0] p, logic [VS:0] a,
                          logic ds, logic zz, logic np, logic [RW-1:0] e);
    int lat;
    set_in(p, a, ds, zz, np);
    out_ready_d[sel] = 1'b1;
    in_valid_d[sel]  = 1'b1;
    @(posedge clk); #1;
    in_valid_d[sel] = 1'b0;
    lat = 1;
    while (!out_valid_d[sel] && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(sel + 1));
    chk(tag, 32'(obs(sel)), 32'(e));
    @(posedge clk); #1;
  endtask

  task automatic stream(int sel, int n);
    int sent, got, cyc;
    logic need_new, stalled;
    logic [RW-1:0] held;
    sent = 0; got = 0; cyc = 0; need_new = 1'b1; stalled = 1'b0; held = '0;
    exp_q.delete();
    while ((sent < n || exp_q.size() > 0) && cyc < 3000) begin
      if (sent < n && need_new) begin
        pm = 16'($urandom_range(0, 16'hFFFF));
        am = ($urandom_range(0, 7) == 0) ? pm : 16'($urandom_range(0, 16'hFFFF));
        diff_sign  = 1'($urandom_range(0, 1));
        z_zero     = ($urandom_range(0, 7) == 0);
        no_product = ($urandom_range(0, 7) == 0);
        need_new   = 1'b0;
      end
      in_valid_d[sel]  = (sent < n);
      out_ready_d[sel] = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (stalled) begin
        chk("stall_hold_valid", 32'(out_valid_d[sel]), 32'd1);
        chk("stall_hold_data", 32'(obs(sel)), 32'(held));
      end
      stalled = out_valid_d[sel] && !out_ready_d[sel];
      held    = obs(sel);
      if (out_valid_d[sel] && out_ready_d[sel]) begin
        if (exp_q.size() == 0) chk("stream_unexpected", 32'(out_valid_d[sel]), 32'd0);
        else begin
          chk("stream_data", 32'(obs(sel)), 32'(exp_q.pop_front()));
          got++;
        end
      end
      if (in_valid_d[sel] && in_ready_d[sel]) begin
        exp_q.push_back(ref_model(pm, am, diff_sign, z_zero, no_product));
        sent++;
        need_new = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid_d[sel] = 1'b0;
    chk("stream_count", 32'(got), 32'(n));
    chk("stream_leftover", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int seen;
    // ---- reset ----
    reset = 1'b1;
    set_in('0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      in_valid_d[i] = 1'b0;
      out_ready_d[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_out_valid", 32'(out_valid_d[i]), 32'd0);
      chk("reset_outputs", 32'(obs(i)), 32'd0);
    end
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) chk("post_reset_in_ready", 32'(in_ready_d[i]), 32'd1);
    @(posedge clk); #1;

    // ---- directed, PIPE=2 ----
    directed("add", 1, 16'h4000, 16'h1000, 1'b0, 1'b0, 1'b0, pack(17'h05000, 1'b0, 1'b0, 5'd2));
    directed("sub_swap", 1, 16'h1000, 16'h4000, 1'b1, 1'b0, 1'b0, pack(17'h03000, 1'b1, 1'b0, 5'd3));
    directed("sub_zero", 1, 16'h2A00, 16'h2A00, 1'b1, 1'b0, 1'b0, pack(17'h0, 1'b0, 1'b1, 5'd17));
    directed("carry", 1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, pack(17'h10000, 1'b0, 1'b0, 5'd0));
    directed("z_zero", 1, 16'h8000, 16'h1234, 1'b1, 1'b1, 1'b0, pack(17'h08000, 1'b0, 1'b0, 5'd1));
    directed("both_zero", 1, 16'h1234, 16'h4321, 1'b1, 1'b1, 1'b1, pack(17'h0, 1'b0, 1'b1, 5'd17));
    // ---- directed, PIPE=1 ----
    directed("p1_no_product", 0, 16'h5555, 16'h0700, 1'b1, 1'b0, 1'b1, pack(17'h00700, 1'b1, 1'b0, 5'd6));
    directed("p1_add", 0, 16'h4000, 16'h1000, 1'b0, 1'b0, 1'b0, pack(17'h05000, 1'b0, 1'b0, 5'd2));

    // ---- backpressure, PIPE=2 ----
    out_ready_d[1] = 1'b0;
    set_in(16'h4000, 16'h1000, 1'b0, 1'b0, 1'b0);
    in_valid_d[1] = 1'b1;
    @(posedge clk); #1;
    set_in(16'h1000, 16'h4000, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    set_in(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    chk("bp_in_ready_low", 32'(in_ready_d[1]), 32'd0);
    chk("bp_out_valid", 32'(out_valid_d[1]), 32'd1);
    chk("bp_a", 32'(obs(1)), 32'(pack(17'h05000, 1'b0, 1'b0, 5'd2)));
    repeat (2) @(posedge clk);
    #1;
    chk("bp_a_hold", 32'(obs(1)), 32'(pack(17'h05000, 1'b0, 1'b0, 5'd2)));
    chk("bp_in_ready_hold", 32'(in_ready_d[1]), 32'd0);
    out_ready_d[1] = 1'b1;
    #1;
    chk("bp_in_ready_release", 32'(in_ready_d[1]), 32'd1);
    @(posedge clk); #1;
    in_valid_d[1] = 1'b0;
    chk("bp_b", 32'(obs(1)), 32'(pack(17'h03000, 1'b1, 1'b0, 5'd3)));
    chk("bp_b_valid", 32'(out_valid_d[1]), 32'd1);
    @(posedge clk); #1;
    chk("bp_c", 32'(obs(1)), 32'(pack(17'h10000, 1'b0, 1'b0, 5'd0)));
    @(posedge clk); #1;
    chk("bp_drained", 32'(out_valid_d[1]), 32'd0);

    // ---- random streaming ----
    stream(1, 100);
    stream(0, 100);

    // ---- reset with two in flight, PIPE=2 ----
    out_ready_d[1] = 1'b0;
    set_in(16'h0123, 16'h0456, 1'b0, 1'b0, 1'b0);
    in_valid_d[1] = 1'b1;
    @(posedge clk); #1;
    set_in(16'h7777, 16'h0001, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_valid_d[1] = 1'b0;
    chk("rst_pre_valid", 32'(out_valid_d[1]), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_valid", 32'(out_valid_d[1]), 32'd0);
    chk("rst_async_outputs", 32'(obs(1)), 32'd0);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("rst_release_in_ready", 32'(in_ready_d[1]), 32'd1);
    out_ready_d[1] = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid_d[1]) seen++;
    end
    chk("rst_no_stale", 32'(seen), 32'd0);

    // ---- report ----
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fma_sum_pipe.md
Name: fma_sum_pipe

Overview:
- Parametrised, pipelined successor to the FMA16 mantissa sum stage.
- Takes aligned product and addend mantissas and forms the magnitude sum or difference, with a carry bit, swap sign, zero flag and leading-zero count.
- Uses a valid/ready handshake with full backpressure.
- Sits between the alignment stage and the normalisation/rounding stage. It serves fp16/fp32/fp64 FMA variants through VEC_SIZE.

Parameters:
VEC_SIZE, 33, MSB index of input mantissas (inputs are VEC_SIZE+1 bits)
PIPE, 2, register stages (1 or 2); any other value is an elaboration error
LZC_W, $clog2(VEC_SIZE+3), width of leading-zero count

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
in_valid  in  1  input transaction valid
in_ready  out  1  block can accept input this cycle
pm  in  VEC_SIZE+1  aligned product mantissa
am  in  VEC_SIZE+1  aligned addend mantissa
diff_sign  in  1  product and addend signs differ (effective subtract)
z_zero  in  1  addend is zero
no_product  in  1  product is zero
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
sm  out  VEC_SIZE+2  magnitude result; MSB is carry-out
swap  out  1  result sign inverted relative to product (am > pm on subtract)
sum_zero  out  1  sm == 0
lzc  out  LZC_W  leading zeros of sm counted from bit VEC_SIZE+1; equals VEC_SIZE+2 when sm == 0

Behaviour:
- One clock domain. reset is asynchronous and active-high. While reset is high, all valid flags, sm, swap, sum_zero and lzc are 0.
- After reset release, in_ready is 1.
- Reset asserted mid-operation discards all in-flight transactions. No output is produced for them.
- Transfer occurs on a rising clk edge when valid && ready on the same interface.
- Arithmetic, evaluated in priority order, zero-extended to VEC_SIZE+2 bits:
  - z_zero && no_product: sm=0, swap=0.
  - z_zero: sm=pm, swap=0.
  - no_product: sm=am, swap=diff_sign.
  - diff_sign: if pm >= am then sm=pm-am, swap=0; else sm=am-pm, swap=1.
  - otherwise: sm=pm+am with carry into bit VEC_SIZE+1, swap=0.
- sum_zero=(sm==0). On a zero difference (pm==am, diff_sign=1), swap=0.
- lzc counts leading zeros over all VEC_SIZE+2 bits.
- PIPE=1: sum and lzc are computed combinationally and registered in one stage. Latency is 1 cycle.
- PIPE=2: stage 1 registers sm, swap and sum_zero. Stage 2 computes lzc from the stage-1 register and registers all outputs. Latency is 2 cycles.
- Each stage has a valid bit. A stage loads when it is empty or when its contents move downstream in the same cycle.
- in_ready = !stage1_valid || stage1_advances. in_ready is combinational from out_ready; there is no skid buffer. Peak throughput is 1 per cycle.
- While out_valid=1 and out_ready=0, all outputs hold stable. Upstream stages fill and then in_ready deasserts.
- Transactions leave in acceptance order; none are dropped or duplicated.
- Accept and emit may occur in the same cycle. The pipeline then stays full with no bubble.
- When in_valid=0, stages drain and out_valid falls after the last result is accepted. Data registers may keep stale values while their valid bit is 0.

Test Plan (VEC_SIZE=15, PIPE=2, out_ready=1 unless stated):
1. pm=0x4000, am=0x1000, diff_sign=0 -> after 2 cycles: sm=0x05000, swap=0, sum_zero=0, lzc=2.
2. pm=0x1000, am=0x4000, diff_sign=1 -> sm=0x03000, swap=1, lzc=3. Then pm=am=0x2A00, diff_sign=1 -> sm=0, sum_zero=1, swap=0, lzc=17.
3. Carry and special cases:
   - pm=0xFFFF, am=0x0001, add -> sm=0x10000, lzc=0.
   - z_zero=1, pm=0x8000 -> sm=0x08000, lzc=1.
   - z_zero=1, no_product=1 -> sm=0, lzc=17.
4. Backpressure: issue A, B, C on back-to-back cycles with out_ready=0.
   - A and B are held; in_ready=0 while C is presented; out_valid=1 with A's outputs stable.
   - Raise out_ready -> A, B, C emerge in order on consecutive cycles.
5. Streaming: 100 random back-to-back transactions with random out_ready -> every result matches the reference model, in order, with no loss or duplication. Repeat with PIPE=1 and check 1-cycle latency.
6. Assert reset with 2 transactions in flight -> out_valid=0 immediately (asynchronous), all outputs 0, in_ready=1 after release, and no stale result appears afterwards.
